pool_window_ctrl: RTL and testbench
===================================

POOL_WINDOW_CTRL -- requirements
Module: pool_window_ctrl

Interface
REQ-001 SHALL have parameter FM_DEPTH, default 64, channels per pixel.
REQ-002 SHALL have parameter FM_WIDTH, default 32, pixels per row; even, >=2.
REQ-003 SHALL have parameter FM_HEIGHT, default 32, rows per frame; even, >=2.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a frame.
REQ-007 SHALL have port busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last window is emitted.
REQ-009 SHALL have port pix_valid  input  1  qualifies pix_in; one pixel per valid cycle, raster order.
REQ-010 SHALL have port pix_in  input  signed 16 x FM_DEPTH  channel vector of one pixel.
REQ-011 SHALL have port win_valid  output  1  drives the pooling datapath data_in_valid.
REQ-012 SHALL have port win_out  output  signed 16 x FM_DEPTH x 4  2x2 window; [0] top-left, [1] top-right, [2] bottom-left, [3] bottom-right.

Function
REQ-013 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when the pixel at (row FM_HEIGHT-1, col FM_WIDTH-1) is accepted; DONE -> IDLE unconditionally after one cycle.
REQ-014 SHALL accept pixels only in RUN with pix_valid high; pix_valid in IDLE or DONE is dropped.
REQ-015 SHALL ignore start while in RUN or DONE.
REQ-016 SHALL keep col (0..FM_WIDTH-1) and row (0..FM_HEIGHT-1) counters, cleared on start; col wraps to 0 and row increments on each accepted last-column pixel.
REQ-017 SHALL write accepted even-row pixels into a FM_WIDTH-entry line buffer at address col.
REQ-018 SHALL hold each accepted even-column pixel of an odd row in a left-pixel register.
REQ-019 SHALL, on acceptance of an odd-row, odd-column pixel, register the window {linebuf[col-1], linebuf[col], left, pix_in} and assert win_valid exactly one cycle later for one cycle (latency 1).
REQ-020 SHALL emit exactly (FM_WIDTH/2)*(FM_HEIGHT/2) windows per frame; no windows otherwise.
REQ-021 SHALL hold win_out stable between win_valid pulses.
REQ-022 SHALL assert busy in RUN and DONE; done is asserted in DONE, coincident with the final win_valid.
REQ-023 SHALL tolerate arbitrary gaps in pix_valid without state change.

Reset
REQ-024 SHALL on rstn low clear FSM to IDLE, counters to 0, busy/done/win_valid to 0, win_out and left register to 0, asynchronously.
REQ-025 SHALL abandon a frame on reset mid-frame; no window from it is emitted after reset release.
REQ-026 Line buffer contents need not be reset; they are never read before being written in a frame.

Configuration
REQ-027 SHALL support macro POOL_WINDOW_CTRL_ERR_EN.
REQ-028 With POOL_WINDOW_CTRL_ERR_EN defined, SHALL add output err (1 bit), set sticky when pix_valid is high in IDLE or DONE, cleared by start or reset.
REQ-029 Without POOL_WINDOW_CTRL_ERR_EN, SHALL omit err port and its logic; dropped pixels are silent.

Structure
REQ-030 SHALL place PIX_W=16, the FSM state enum (IDLE, RUN, DONE) and window index constants (TL=0, TR=1, BL=2, BR=3) in shared package pool_pkg.
REQ-031 SHALL implement the line buffer as sub-module pool_line_buf (one write port, two combinational read ports at col-1 and col).

Verification
REQ-032 FM_WIDTH=4, FM_HEIGHT=2, FM_DEPTH=1, start then pixels 1..8 back-to-back -> win_valid at cycles after pixel 6 and pixel 8; windows {1,2,5,6} and {3,4,7,8}; done with second window.
REQ-033 Same frame with pix_valid low every other cycle -> identical windows, each one cycle after pixels 6 and 8.
REQ-034 start pulsed again during RUN -> ignored; counters continue; 2 windows total.
REQ-035 rstn low after pixel 6 accepted (before win_valid) -> win_valid, busy, done 0; next frame with pixels 11..18 -> windows {11,12,15,16}, {13,14,17,18}.
REQ-036 With POOL_WINDOW_CTRL_ERR_EN, pix_valid high in IDLE -> err=1, no window; next start -> err=0.
REQ-037 Signed values -32768 and 32767 in all window slots -> win_out carries them unaltered.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling window controller.
package pool_pkg;

    // Width of one signed channel sample.
    localparam int PIX_W = 16;

    // Window slot indices inside win_out.
    localparam int TL = 0;
    localparam int TR = 1;
    localparam int BL = 2;
    localparam int BR = 3;

    // Frame controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer: single write port, two combinational read ports.
// Holds the even row of a row pair so the odd row can form 2x2 windows.
module pool_line_buf #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr0_i,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic [AW-1:0]     raddr1_i,
    output logic [DATA_W-1:0] rdata1_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is written before it is read within every frame, so no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/pool_window_ctrl.sv
// 2x2 pooling window controller: collects a raster-order frame and emits
// one 2x2 window per odd-row/odd-column pixel, one cycle after acceptance.
// Optional feature macro: POOL_WINDOW_CTRL_ERR_EN adds a sticky err output
// flagging pixels presented while no frame is running.
module pool_window_ctrl
    import pool_pkg::*;
#(
    parameter int FM_DEPTH  = 64,
    parameter int FM_WIDTH  = 32,
    parameter int FM_HEIGHT = 32
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    input  logic                                    pix_valid,
    input  logic signed [FM_DEPTH-1:0][PIX_W-1:0]   pix_in,
    output logic                                    win_valid,
    output logic signed [3:0][FM_DEPTH-1:0][PIX_W-1:0] win_out
`ifdef POOL_WINDOW_CTRL_ERR_EN
    ,
    output logic                                    err
`endif
);

    localparam int CW = (FM_WIDTH  > 1) ? $clog2(FM_WIDTH)  : 1;
    localparam int RW = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;
    localparam int DW = FM_DEPTH * PIX_W;
    localparam logic [CW-1:0] COL_LAST = CW'(FM_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FM_HEIGHT - 1);

    state_e          state_q;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DW-1:0]   left_q;
    logic signed [3:0][FM_DEPTH-1:0][PIX_W-1:0] win_q;
    logic            win_valid_q;
    logic            busy_q;
    logic            done_q;

    logic            accept;
    logic            frame_end;
    logic            lb_we;
    logic            emit;
    logic [CW-1:0]   col_m1;
    logic [DW-1:0]   lb_rd_left;
    logic [DW-1:0]   lb_rd_right;

    assign accept    = (state_q == RUN) && pix_valid;
    assign frame_end = accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign lb_we     = accept && !row_q[0];
    assign emit      = accept && row_q[0] && col_q[0];
    // Only consumed on odd columns, so col-1 never underflows when used.
    assign col_m1    = col_q - CW'(1);

    // Raster position after the current pixel is accepted.
    always_comb begin
        col_d = col_q + CW'(1);
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end
    end

    pool_line_buf #(
        .DEPTH  (FM_WIDTH),
        .DATA_W (DW),
        .AW     (CW)
    ) u_line_buf (
        .clk_i    (clk),
        .we_i     (lb_we),
        .waddr_i  (col_q),
        .wdata_i  (pix_in),
        .raddr0_i (col_m1),
        .rdata0_o (lb_rd_left),
        .raddr1_i (col_q),
        .rdata1_o (lb_rd_right)
    );

    // Frame FSM with counters, left-pixel hold and registered window outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            left_q      <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        col_q <= col_d;
                        row_q <= row_d;
                        if (row_q[0] && !col_q[0]) left_q <= pix_in;
                        if (emit) begin
                            win_q[TL]   <= lb_rd_left;
                            win_q[TR]   <= lb_rd_right;
                            win_q[BL]   <= left_q;
                            win_q[BR]   <= pix_in;
                            win_valid_q <= 1'b1;
                        end
                        if (frame_end) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign win_valid = win_valid_q;
    assign win_out   = win_q;

`ifdef POOL_WINDOW_CTRL_ERR_EN
    logic err_q;

    // Sticky flag for pixels offered outside RUN; a new frame clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            err_q <= 1'b0;
        end else if (pix_valid && state_q != RUN) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Directed bench for pool_window_ctrl on a 4x2 single-channel frame.
module tb_pool_window_ctrl;
    import pool_pkg::*;

    logic               clk = 1'b0;
    logic               rstn;
    logic               start;
    logic               busy;
    logic               done;
    logic               pix_valid;
    logic signed [0:0][15:0]      pix_in;
    logic               win_valid;
    logic signed [3:0][0:0][15:0] win_out;
`ifdef POOL_WINDOW_CTRL_ERR_EN
    logic               err;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] px [8];

    pool_window_ctrl #(
        .FM_DEPTH  (1),
        .FM_WIDTH  (4),
        .FM_HEIGHT (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .win_valid (win_valid),
        .win_out   (win_out)
`ifdef POOL_WINDOW_CTRL_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] w4(input logic [15:0] tl, input logic [15:0] tr,
                                       input logic [15:0] bl, input logic [15:0] br);
        return {br, bl, tr, tl};
    endfunction

    // Drive one cycle of pixel input, then sample just after the edge.
    task automatic cyc(input logic v, input logic [15:0] d);
        pix_valid = v;
        pix_in    = d;
        @(posedge clk);
        #1;
    endtask

    // One full frame from px[]; optional idle gap before each pixel and an
    // optional extra start pulse alongside pixel index restart_at.
    task automatic run_frame(input string nm, input bit gap, input int restart_at);
        logic [63:0] w1, w2;
        w1 = w4(px[0], px[1], px[4], px[5]);
        w2 = w4(px[2], px[3], px[6], px[7]);
        start = 1'b1;
        cyc(1'b0, 16'h0);
        start = 1'b0;
        chk({nm, "_busy_start"}, busy, 1);
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                cyc(1'b0, 16'h0);
                chk({nm, "_gap_wv"}, win_valid, 0);
            end
            start = (i == restart_at);
            cyc(1'b1, px[i]);
            start = 1'b0;
            chk($sformatf("%s_wv%0d", nm, i), win_valid, (i == 5 || i == 7) ? 1 : 0);
            if (i == 5) chk({nm, "_win1"}, win_out, w1);
            if (i == 6) chk({nm, "_win1_hold"}, win_out, w1);
            if (i == 7) chk({nm, "_win2"}, win_out, w2);
            chk($sformatf("%s_done%0d", nm, i), done, (i == 7) ? 1 : 0);
        end
        chk({nm, "_busy_done"}, busy, 1);
        cyc(1'b0, 16'h0);
        chk({nm, "_busy_end"}, busy, 0);
        chk({nm, "_done_end"}, done, 0);
        chk({nm, "_wv_end"}, win_valid, 0);
        chk({nm, "_win2_hold"}, win_out, w2);
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wv", win_valid, 0);
        chk("rst_win", win_out, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Pixels in IDLE are dropped and produce no window.
        cyc(1'b1, 16'd55);
        chk("idle_wv", win_valid, 0);
        chk("idle_busy", busy, 0);
`ifdef POOL_WINDOW_CTRL_ERR_EN
        chk("err_set", err, 1);
`endif
        cyc(1'b0, 16'h0);

        for (int i = 0; i < 8; i++) px[i] = 16'(i + 1);
        run_frame("b2b", 1'b0, -1);
`ifdef POOL_WINDOW_CTRL_ERR_EN
        chk("err_clr", err, 0);
`endif
        run_frame("gap", 1'b1, -1);
        run_frame("restart", 1'b0, 2);

        // Reset in the middle of a frame, just after pixel 6 is taken.
        start = 1'b1;
        cyc(1'b0, 16'h0);
        start = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, px[i]);
        pix_valid = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_wv", win_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_win", win_out, 64'h0);
        cyc(1'b1, 16'd99);
        rstn = 1'b1;
        cyc(1'b1, 16'd99);
        chk("post_rst_wv", win_valid, 0);
        cyc(1'b0, 16'h0);
        chk("post_rst_wv2", win_valid, 0);
        chk("post_rst_busy", busy, 0);
        for (int i = 0; i < 8; i++) px[i] = 16'(i + 11);
        run_frame("after_rst", 1'b0, -1);

        // Signed extremes in every slot.
        px[0] = 16'h8000; px[1] = 16'h7FFF; px[2] = 16'h7FFF; px[3] = 16'h8000;
        px[4] = 16'h7FFF; px[5] = 16'h8000; px[6] = 16'h8000; px[7] = 16'h7FFF;
        run_frame("signed", 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
